// File: rtl/regfile_bist_pkg.sv
// Shared types and constants for the register-file BIST engine.
// Optional fail log is enabled by defining REGFILE_BIST_FAIL_LOG_EN.
package regfile_bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_CHECK,
    S_FINISH
  } state_e;

  localparam logic [1:0] MODE_INDEX     = 2'd0;
  localparam logic [1:0] MODE_ONES      = 2'd1;
  localparam logic [1:0] MODE_CHECKER   = 2'd2;
  localparam logic [1:0] MODE_INV_INDEX = 2'd3;

  // Checkerboard bit pairs: even index -> 0xA.., odd index -> 0x5..
  localparam logic [1:0] CHK_EVEN = 2'b10;
  localparam logic [1:0] CHK_ODD  = 2'b01;

endpackage

// File: rtl/regfile_bist_pattern.sv
// Combinational test-pattern generator shared by write and compare paths.
// Patterns are truncated to DATA_WIDTH.
module regfile_bist_pattern
  import regfile_bist_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic [1:0]            mode,
  input  logic [ADDR_WIDTH-1:0] index,
  output logic [DATA_WIDTH-1:0] pattern
);

  logic [DATA_WIDTH-1:0] idx_pat;
  logic [DATA_WIDTH-1:0] chk_pat;

  always_comb begin
    idx_pat = (DATA_WIDTH'(index) << 4) | DATA_WIDTH'(1);
    chk_pat = '0;
    for (int b = 0; b < DATA_WIDTH; b++) begin
      chk_pat[b] = index[0] ? CHK_ODD[b[0]] : CHK_EVEN[b[0]];
    end
    pattern = '0;
    unique case (mode)
      MODE_INDEX:     pattern = idx_pat;
      MODE_ONES:      pattern = '1;
      MODE_CHECKER:   pattern = chk_pat;
      MODE_INV_INDEX: pattern = ~idx_pat;
      default:        pattern = '0;
    endcase
  end

endmodule

// File: rtl/regfile_bist.sv
// Write/read/compare BIST engine for a two-read-port register file.
// Define REGFILE_BIST_FAIL_LOG_EN to add first-mismatch capture ports.
module regfile_bist
  import regfile_bist_pkg::*;
#(
  parameter int DATA_WIDTH         = 32,
  parameter int ADDR_WIDTH         = 5,
  parameter int NUM_REGS           = 32,
  parameter int ZERO_REG_HARDWIRED = 1,
  parameter int ERR_WIDTH          = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            mode,
  output logic                  ctrl_writeEnable,
  output logic [ADDR_WIDTH-1:0] ctrl_writeReg,
  output logic [DATA_WIDTH-1:0] data_writeReg,
  output logic [ADDR_WIDTH-1:0] ctrl_readRegA,
  output logic [ADDR_WIDTH-1:0] ctrl_readRegB,
  input  logic [DATA_WIDTH-1:0] data_readRegA,
  input  logic [DATA_WIDTH-1:0] data_readRegB,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_WIDTH-1:0]  error_count
`ifdef REGFILE_BIST_FAIL_LOG_EN
  ,
  output logic                  fail_valid,
  output logic [ADDR_WIDTH-1:0] fail_reg,
  output logic                  fail_port,
  output logic [DATA_WIDTH-1:0] fail_data
`endif
);

  localparam logic [ERR_WIDTH-1:0]  ERR_MAX = '1;
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(NUM_REGS - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] index_q, index_d;
  logic [1:0]            mode_q, mode_d;
  logic [ERR_WIDTH-1:0]  err_q, err_d;
  logic                  pass_q, pass_d;

  logic [DATA_WIDTH-1:0] pat;
  logic [DATA_WIDTH-1:0] exp_val;
  logic                  mis_a, mis_b;
  logic [ERR_WIDTH+1:0]  err_sum;
  logic [ERR_WIDTH-1:0]  err_sat;
  logic                  accept;

  regfile_bist_pattern #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_pat (
    .mode   (mode_q),
    .index  (index_q),
    .pattern(pat)
  );

  // Register 0 may read as zero regardless of what was written.
  always_comb begin
    exp_val = pat;
    if (ZERO_REG_HARDWIRED != 0 && index_q == '0) exp_val = '0;
    mis_a   = data_readRegA != exp_val;
    mis_b   = data_readRegB != exp_val;
    err_sum = {2'b00, err_q}
            + {{(ERR_WIDTH+1){1'b0}}, mis_a}
            + {{(ERR_WIDTH+1){1'b0}}, mis_b};
    err_sat = (err_sum > {2'b00, ERR_MAX}) ? ERR_MAX
                                           : err_sum[ERR_WIDTH-1:0];
  end

  assign accept = (state_q == S_IDLE) && start;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      index_q <= '0;
      mode_q  <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    index_d          = index_q;
    mode_d           = mode_q;
    err_d            = err_q;
    pass_d           = pass_q;
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = '0;
    data_writeReg    = '0;
    ctrl_readRegA    = '0;
    ctrl_readRegB    = '0;
    done             = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          index_d = '0;
          mode_d  = mode;
          err_d   = '0;
          pass_d  = 1'b0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = index_q;
        data_writeReg    = pat;
        state_d          = S_READ;
      end
      S_READ: begin
        ctrl_readRegA = index_q;
        ctrl_readRegB = index_q;
        state_d       = S_CHECK;
      end
      S_CHECK: begin
        ctrl_readRegA = index_q;
        ctrl_readRegB = index_q;
        err_d         = err_sat;
        if (index_q == LAST) begin
          state_d = S_FINISH;
        end else begin
          index_d = index_q + ADDR_WIDTH'(1);
          state_d = S_WRITE;
        end
      end
      S_FINISH: begin
        done    = 1'b1;
        pass_d  = (err_q == '0);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy        = (state_q != S_IDLE);
  assign pass        = pass_q;
  assign error_count = err_q;

`ifdef REGFILE_BIST_FAIL_LOG_EN
  logic                  fv_q, fv_d;
  logic [ADDR_WIDTH-1:0] freg_q, freg_d;
  logic                  fport_q, fport_d;
  logic [DATA_WIDTH-1:0] fdata_q, fdata_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fv_q    <= 1'b0;
      freg_q  <= '0;
      fport_q <= 1'b0;
      fdata_q <= '0;
    end else begin
      fv_q    <= fv_d;
      freg_q  <= freg_d;
      fport_q <= fport_d;
      fdata_q <= fdata_d;
    end
  end

  // Only the first mismatch of a pass is kept; port A wins a tie.
  always_comb begin
    fv_d    = fv_q;
    freg_d  = freg_q;
    fport_d = fport_q;
    fdata_d = fdata_q;
    if (accept) begin
      fv_d    = 1'b0;
      freg_d  = '0;
      fport_d = 1'b0;
      fdata_d = '0;
    end else if (state_q == S_CHECK && !fv_q && (mis_a || mis_b)) begin
      fv_d    = 1'b1;
      freg_d  = index_q;
      fport_d = !mis_a;
      fdata_d = mis_a ? data_readRegA : data_readRegB;
    end
  end

  assign fail_valid = fv_q;
  assign fail_reg   = freg_q;
  assign fail_port  = fport_q;
  assign fail_data  = fdata_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: doc/regfile_bist.md
REGFILE_BIST -- requirements
Module: regfile_bist

Interface
REQ-001 Parameter DATA_WIDTH, default 32, register data width in bits.
REQ-002 Parameter ADDR_WIDTH, default 5, register index width.
REQ-003 Parameter NUM_REGS, default 32, number of registers tested (indices 0..NUM_REGS-1, NUM_REGS <= 2**ADDR_WIDTH).
REQ-004 Parameter ZERO_REG_HARDWIRED, default 1, when 1 the expected read value of register 0 is all zeros.
REQ-005 Parameter ERR_WIDTH, default 8, error counter width.
REQ-006 clock  input  1  single master clock; all state updates on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 start  input  1  single-cycle request to begin a test pass.
REQ-009 mode  input  2  pattern select, sampled on accepted start.
REQ-010 ctrl_writeEnable  output  1  register file write enable.
REQ-011 ctrl_writeReg  output  ADDR_WIDTH  register file write index.
REQ-012 data_writeReg  output  DATA_WIDTH  register file write data.
REQ-013 ctrl_readRegA / ctrl_readRegB  output  ADDR_WIDTH each  read-port indices.
REQ-014 data_readRegA / data_readRegB  input  DATA_WIDTH each  read-port data.
REQ-015 busy  output  1  high while a pass is running.
REQ-016 done  output  1  single-cycle pulse when a pass completes.
REQ-017 pass  output  1  high after done when error_count is 0; holds until next accepted start.
REQ-018 error_count  output  ERR_WIDTH  number of mismatching compares in the current or last pass.

Function
REQ-019 The FSM SHALL have the states IDLE, WRITE, READ, CHECK and FINISH.
REQ-020 In IDLE, start=1 SHALL be accepted: index cleared to 0, mode latched, error_count cleared, pass cleared, next state WRITE.
REQ-021 WRITE SHALL assert ctrl_writeEnable=1 for exactly one cycle, with ctrl_writeReg=index and data_writeReg=pattern(mode,index); next state READ.
REQ-022 READ SHALL drive ctrl_writeEnable=0 and ctrl_readRegA=ctrl_readRegB=index; next state CHECK.
REQ-023 CHECK SHALL hold the read indices, compare both data_readRegA and data_readRegB against the expected value, and increment error_count once per mismatching port (0, 1 or 2 per register).
REQ-024 Expected value SHALL be 0 for index 0 when ZERO_REG_HARDWIRED=1; otherwise pattern(mode,index).
REQ-025 After CHECK the FSM SHALL go to WRITE with index+1 if index < NUM_REGS-1; otherwise to FINISH.
REQ-026 Patterns, truncated to DATA_WIDTH: mode 0 = (index<<4)|1; mode 1 = all ones; mode 2 = 0xAA..A when index is even, 0x55..5 when index is odd; mode 3 = bitwise NOT of mode 0.
REQ-027 FINISH SHALL pulse done for one cycle, set pass=(error_count==0), and return to IDLE.
REQ-028 Latency: start accepted at cycle 0 SHALL produce done at cycle 3*NUM_REGS+1.
REQ-029 busy SHALL be 1 in WRITE, READ, CHECK and FINISH, and 0 in IDLE.
REQ-030 start while busy SHALL be ignored.
REQ-031 error_count SHALL saturate at 2**ERR_WIDTH-1 and SHALL NOT wrap.
REQ-032 In IDLE, all ctrl_* outputs and data_writeReg SHALL be 0.

Reset
REQ-033 reset SHALL asynchronously force IDLE and set index=0, error_count=0, pass=0, done=0, busy=0, ctrl_writeEnable=0, and all indices and write data to 0.
REQ-034 reset asserted during a pass SHALL abort it with no done pulse; the first start after reset release SHALL begin a fresh pass.

Configuration
REQ-035 With macro REGFILE_BIST_FAIL_LOG_EN defined, the module SHALL add outputs fail_valid (1), fail_reg (ADDR_WIDTH), fail_port (1, 0=A, 1=B) and fail_data (DATA_WIDTH), capturing the first mismatch of a pass (port A takes priority) and clearing them on accepted start or reset.
REQ-036 Without REGFILE_BIST_FAIL_LOG_EN, these ports and their logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-037 Shared package regfile_bist_pkg SHALL hold the FSM state encoding, the mode encodings (MODE_INDEX, MODE_ONES, MODE_CHECKER, MODE_INV_INDEX) and the checkerboard constants.
REQ-038 Pattern generation SHALL be a combinational sub-module named regfile_bist_pattern (inputs mode and index; output pattern), instantiated once and used for both write data and expected data.

Verification
REQ-039 Ideal regfile model, mode 0, NUM_REGS=32: reg 5 is written with 0x00000051, reg 31 with 0x000001F1; done is seen at cycle 97; pass=1; error_count=0.
REQ-040 Model with port B of reg 7 stuck at 0x0, mode 1: error_count=1, pass=0; with FAIL_LOG_EN, fail_reg=7, fail_port=1, fail_data=0x00000000.
REQ-041 Model with reg 0 not hardwired and ZERO_REG_HARDWIRED=1, mode 2: reg 0 reads 0xAAAAAAAA on both ports, giving error_count=2.
REQ-042 ERR_WIDTH=2, model returning 0 on all reads, mode 1: error_count saturates at 3.
REQ-043 reset pulsed at cycle 40 of a pass: busy and ctrl_writeEnable drop immediately, no done pulse occurs, and a new start completes normally.
REQ-044 start re-pulsed at cycle 10 of a pass: ignored; done still occurs at cycle 97.
